mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register of the 8-bit five-stage CPU.
- Consumes the EX/MEM register outputs (WBregwr, WBregomem, MEMwr, ALUout, constant, writeREG, readDATA2).
- Performs data-memory store/load, registers the results into MEM/WB, and drives the register-file writeback port and the forwarding taps.

Parameters:
- DEPTH, 32, number of 8-bit data-memory words; must be a power of two, 2..256.
- AW, 5, memory address bits, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- WBregwr  in  1  register-write enable from EX/MEM.
- WBregomem  in  1  writeback source select from EX/MEM: 1 = memory data, 0 = ALUout.
- MEMwr  in  1  data-memory write enable from EX/MEM.
- ALUout  in  8  memory address and ALU result.
- constant  in  8  immediate carried down the pipe.
- writeREG  in  3  destination register.
- readDATA2  in  8  store data.
- hold  in  1  stall: freeze MEM/WB and suppress the memory write.
- flush  in  1  insert a bubble into MEM/WB.
- wb_regwr  out  1  register-file write enable.
- wb_reg  out  3  register-file write address.
- wb_data  out  8  register-file write data.
- wb_constant  out  8  registered constant.
- mem_fwd_data  out  8  combinational MEM-stage result for the forwarding unit.
- store_count  out  8  number of committed stores, saturating.

Behaviour:
- Reset (rst=0), asynchronous, takes effect immediately:
  - wb_regwr=0, wb_reg=0, wb_data=0, wb_constant=0, store_count=0.
  - Internal MEM/WB source-select and data registers clear to 0.
  - Memory array contents are not reset.
- Address: addr = ALUout[AW-1:0]. Upper bits are ignored, so an address ≥ DEPTH wraps modulo DEPTH.
- Memory read: asynchronous. rdata = mem[addr].
- Memory write: synchronous on posedge clk when MEMwr=1 and hold=0 and rst=1. mem[addr] <= readDATA2.
- mem_fwd_data, combinational: WBregomem ? rdata : ALUout.
- MEM/WB register, updated on posedge clk:
  - hold=1 has priority over flush: all MEM/WB registers keep their value, no store occurs, store_count unchanged.
  - flush=1 (hold=0): wb_regwr <= 0. Other fields load normally but are don't-care. The memory write is still performed, because the instruction in MEM is committed; flush kills only the next WB.
  - Normal: wb_regwr <= WBregwr; wb_reg <= writeREG; wb_constant <= constant; wb_data <= mem_fwd_data.
- Load latency: data loaded from address A is visible on wb_data 1 cycle after the load is in MEM.
- Store followed by a load to the same address in the next cycle: the load reads the new value, because the write completes at the edge that separates them.
- Simultaneous MEMwr=1 and WBregomem=1 in the same instruction: wb_data captures the old mem[addr] (read-before-write). The new value is stored.
- store_count: increments on each committed store (MEMwr=1, hold=0). Saturates at 8'hFF.
- Reset asserted mid-store: the write is abandoned. mem[addr] is unchanged if rst falls before the edge.

Test Plan:
1. Reset: rst=0 with all inputs at random values → all outputs 0 immediately, without waiting for a clk edge. Release, idle → outputs stay 0.
2. Store then load:
   - Cycle 0: MEMwr=1, ALUout=8'h05, readDATA2=8'hA7.
   - Cycle 1: MEMwr=0, WBregomem=1, WBregwr=1, ALUout=8'h05, writeREG=3.
   - → after edge 2: wb_data=8'hA7, wb_reg=3, wb_regwr=1, store_count=1.
3. ALU path: WBregomem=0, ALUout=8'h3C, constant=8'h11, WBregwr=1, writeREG=6 → next cycle wb_data=8'h3C, wb_constant=8'h11, wb_reg=6. mem_fwd_data=8'h3C combinationally in the same cycle.
4. Wrap: store 8'h5A at ALUout=8'h25 (DEPTH=32), then load ALUout=8'h05 → wb_data=8'h5A.
5. Hold/flush:
   - hold=1 with MEMwr=1, ALUout=8'h02, readDATA2=8'hFF → mem[2] unchanged, outputs frozen, store_count unchanged.
   - flush=1 with WBregwr=1 → next cycle wb_regwr=0.
   - hold=1 and flush=1 together → hold wins, outputs frozen.
6. Saturation: 300 consecutive stores → store_count=8'hFF and stays there. Then assert rst mid-burst → store_count=0 asynchronously.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB register: async-read data RAM, sync write, forwarding tap, writeback port.
// Latency: loads and ALU results reach wb_data one cycle after the MEM stage; hold freezes and flush bubbles.
module mem_wb_stage #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       WBregwr,
  input  logic       WBregomem,
  input  logic       MEMwr,
  input  logic [7:0] ALUout,
  input  logic [7:0] constant,
  input  logic [2:0] writeREG,
  input  logic [7:0] readDATA2,
  input  logic       hold,
  input  logic       flush,
  output logic       wb_regwr,
  output logic [2:0] wb_reg,
  output logic [7:0] wb_data,
  output logic [7:0] wb_constant,
  output logic [7:0] mem_fwd_data,
  output logic [7:0] store_count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] addr;
  logic [7:0]    rdata;
  logic          store_en;

  logic       wb_regwr_q, wb_regwr_d;
  logic [2:0] wb_reg_q, wb_reg_d;
  logic [7:0] wb_data_q, wb_data_d;
  logic [7:0] wb_constant_q, wb_constant_d;
  logic [7:0] store_count_q, store_count_d;

  // Upper address bits are dropped, so out-of-range addresses alias modulo DEPTH.
  assign addr         = ALUout[AW-1:0];
  assign rdata        = mem_q[addr];
  assign mem_fwd_data = WBregomem ? rdata : ALUout;
  assign store_en     = MEMwr && !hold;

  // Contents survive reset; an asserted reset only blocks the write at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
    end else if (store_en) begin
      mem_q[addr] <= readDATA2;
    end
  end

  always_comb begin
    wb_regwr_d    = wb_regwr_q;
    wb_reg_d      = wb_reg_q;
    wb_data_d     = wb_data_q;
    wb_constant_d = wb_constant_q;
    store_count_d = store_count_q;
    if (!hold) begin
      // A flushed slot still commits its store; only the following writeback is killed.
      wb_regwr_d    = flush ? 1'b0 : WBregwr;
      wb_reg_d      = writeREG;
      wb_data_d     = mem_fwd_data;
      wb_constant_d = constant;
      if (MEMwr && store_count_q != 8'hFF) begin
        store_count_d = store_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_regwr_q    <= 1'b0;
      wb_reg_q      <= 3'd0;
      wb_data_q     <= 8'd0;
      wb_constant_q <= 8'd0;
      store_count_q <= 8'd0;
    end else begin
      wb_regwr_q    <= wb_regwr_d;
      wb_reg_q      <= wb_reg_d;
      wb_data_q     <= wb_data_d;
      wb_constant_q <= wb_constant_d;
      store_count_q <= store_count_d;
    end
  end

  assign wb_regwr    = wb_regwr_q;
  assign wb_reg      = wb_reg_q;
  assign wb_data     = wb_data_q;
  assign wb_constant = wb_constant_q;
  assign store_count = store_count_q;

endmodule
